ssp_rx: RTL
===========

# ssp_rx

Receive half of the SSP serial port. Deserializes 8-bit frames arriving on SSPRXD, framed by SSPFSSIN and timed by SSPCLKIN, and buffers them in a 4-entry receive FIFO. The FIFO is drained over the PSEL/PWRITE bus. It is the counterpart of the SSP transmit path: a peer's SSPTXD, SSPCLKOUT and SSPFSSOUT connect directly to SSPRXD, SSPCLKIN and SSPFSSIN.

## Interface
- DEPTH, 4, receive FIFO entries; must be a power of 2 and at least 2.
- PCLK  in  1  sole clock; all state updates on the rising edge.
- CLEAR_B  in  1  reset; asynchronous, active-low.
- PSEL  in  1  active-high select.
- PWRITE  in  1  0 = read (pop) request when PSEL=1; 1 = ignored by this block.
- SSPCLKIN  in  1  serial bit clock, period 2×PCLK, sampled in the PCLK domain.
- SSPFSSIN  in  1  frame sync; high on the SSPCLKIN edge before the MSB.
- SSPRXD  in  1  serial data, MSB first.
- PRDATA  out  8  FIFO head word; 0x00 when the FIFO is empty.
- SSPRXINTR  out  1  high while the FIFO holds DEPTH words (full).
- SSPRXOVR  out  1  one-PCLK pulse when a completed word is dropped on overrun.

## Operation
- Edge detection: sclk_q <= SSPCLKIN every PCLK.
  - rx_edge = SSPCLKIN & ~sclk_q.
  - All serial actions occur only on PCLK edges where rx_edge=1.
  - SSPRXD and SSPFSSIN are sampled on that same PCLK edge.
- FSM states:
  - IDLE: on rx_edge with SSPFSSIN=1, go to SHIFT with bitcnt=7.
  - SHIFT: on each rx_edge, shreg <= {shreg[6:0], SSPRXD} and bitcnt decrements.
    - SSPFSSIN is ignored while bitcnt is 7..1.
    - At bitcnt=0 the word {shreg[6:0], SSPRXD} completes and is pushed.
    - If SSPFSSIN=1 on that same edge, stay in SHIFT with bitcnt=7 (back-to-back frame, no gap).
    - Otherwise, go to IDLE.
- FIFO: registered storage, wr_ptr/rd_ptr of log2(DEPTH) bits each, count of log2(DEPTH)+1 bits. Pointers wrap modulo DEPTH.
  - Pop: occurs when PSEL=1, PWRITE=0 and count>0. An empty read has no effect and PRDATA stays 0x00.
  - Push: occurs on word completion when count<DEPTH, or when count==DEPTH and a pop happens in the same cycle. In that case both occur and count stays DEPTH.
  - Overrun: word completion with count==DEPTH and no pop. The word is discarded, FIFO contents are unchanged, and SSPRXOVR=1 for one cycle.
  - Simultaneous push and pop with 0<count<DEPTH: count is unchanged and both pointers advance.
- SSPRXINTR is registered: (next count == DEPTH).
- PRDATA = mem[rd_ptr] when count>0, else 0x00.

## Timing
- Reset values (CLEAR_B low, immediate and asynchronous):
  - FSM = IDLE, bitcnt = 0, shreg = 0.
  - sclk_q = 1, which suppresses a spurious edge if SSPCLKIN is high at release.
  - Pointers = 0, count = 0.
  - PRDATA = 0x00, SSPRXINTR = 0, SSPRXOVR = 0.
- A frame occupies 9 rx_edges: 1 sync edge plus 8 data edges. Back-to-back frames occupy 8 edges each after the first.
- Receive latency: the word is pushed on the PCLK edge detecting the LSB rx_edge. It appears on PRDATA after that edge (0 extra cycles) if the FIFO was empty.
- Pop takes effect on the PCLK edge. The next word, or 0x00, is on PRDATA after that edge.
- SSPRXINTR rises after the edge of the DEPTH-th push and falls after the edge of the first pop from full.
- Reset mid-frame discards the partial word and FIFO contents. The first rx_edge with SSPFSSIN=1 after release starts a new frame.

## Test plan
- Reset: assert CLEAR_B=0 mid-stream -> PRDATA=0x00, SSPRXINTR=0, SSPRXOVR=0 immediately; no pop effect while in reset.
- Single frame: send 0xA5 -> PRDATA=0xA5 after the LSB edge. One read (PSEL=1, PWRITE=0) -> PRDATA=0x00. A read with PWRITE=1 leaves 0xA5 in place.
- Back-to-back fill: send 0x11, 0x22, 0x33, 0x44 with SSPFSSIN high on each LSB edge -> SSPRXINTR=1 after the 4th. Four reads return 0x11..0x44 in order; SSPRXINTR drops after the first read.
- Overrun: with the FIFO full (0x11..0x44), send 0x55 with no reads -> one SSPRXOVR pulse. Reads still return 0x11, 0x22, 0x33, 0x44, then 0x00.
- Push+pop at full: FIFO full, and a read coincides with the 0x66 LSB edge -> no SSPRXOVR, SSPRXINTR stays 1. Reads return 0x22, 0x33, 0x44, 0x66.
- Reset mid-frame: pull CLEAR_B low after 4 bits of 0xF0, release, then send 0x3C -> PRDATA=0x3C with no stale bits; FIFO count=1.

Source files
------------

// File: rtl/ssp_rx.sv
// SSP receive path: serial frame deserializer feeding a small receive FIFO.
// The FIFO is drained by PSEL/PWRITE read requests; the head word is on PRDATA.
module ssp_rx #(
  parameter int DEPTH = 4
) (
  input  logic       PCLK,
  input  logic       CLEAR_B,
  input  logic       PSEL,
  input  logic       PWRITE,
  input  logic       SSPCLKIN,
  input  logic       SSPFSSIN,
  input  logic       SSPRXD,
  output logic [7:0] PRDATA,
  output logic       SSPRXINTR,
  output logic       SSPRXOVR
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  typedef enum logic {
    IDLE,
    SHIFT
  } state_e;

  state_e          state_q, state_d;
  logic [2:0]      bitcnt_q, bitcnt_d;
  logic [7:0]      shreg_q, shreg_d;
  logic            sclk_q;
  logic            rx_edge;
  logic            done;
  logic [7:0]      word;

  logic [7:0]      mem [DEPTH];
  logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]   count_q, count_d;
  logic            intr_q, ovr_q;
  logic            pop, push, ovr_d, full;

  assign rx_edge = SSPCLKIN & ~sclk_q;
  assign word    = {shreg_q[6:0], SSPRXD};

  always_ff @(posedge PCLK or negedge CLEAR_B) begin
    if (!CLEAR_B) begin
      sclk_q   <= 1'b1;
      state_q  <= IDLE;
      bitcnt_q <= 3'd0;
      shreg_q  <= 8'h00;
    end else begin
      sclk_q   <= SSPCLKIN;
      state_q  <= state_d;
      bitcnt_q <= bitcnt_d;
      shreg_q  <= shreg_d;
    end
  end

  // Frame sync on the LSB edge chains straight into the next frame.
  always_comb begin
    state_d  = state_q;
    bitcnt_d = bitcnt_q;
    shreg_d  = shreg_q;
    done     = 1'b0;
    if (rx_edge) begin
      unique case (state_q)
        IDLE: begin
          if (SSPFSSIN) begin
            state_d  = SHIFT;
            bitcnt_d = 3'd7;
          end
        end
        SHIFT: begin
          shreg_d = word;
          if (bitcnt_q == 3'd0) begin
            done = 1'b1;
            if (SSPFSSIN) begin
              bitcnt_d = 3'd7;
            end else begin
              state_d  = IDLE;
              bitcnt_d = 3'd0;
            end
          end else begin
            bitcnt_d = bitcnt_q - 3'd1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign full  = (count_q == FULL);
  assign pop   = PSEL & ~PWRITE & (count_q != '0);
  assign push  = done & (~full | pop);
  assign ovr_d = done & full & ~pop;

  always_comb begin
    count_d = count_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge PCLK or negedge CLEAR_B) begin
    if (!CLEAR_B) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      intr_q   <= 1'b0;
      ovr_q    <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_d;
      intr_q  <= (count_d == FULL);
      ovr_q   <= ovr_d;
    end
  end

  // Storage needs no reset: count gates every read of it.
  always_ff @(posedge PCLK) begin
    if (push) mem[wr_ptr_q] <= word;
  end

  assign PRDATA    = (count_q != '0) ? mem[rd_ptr_q] : 8'h00;
  assign SSPRXINTR = intr_q;
  assign SSPRXOVR  = ovr_q;

endmodule
